// File: rtl/bcd_count2_if.sv
// Control and digit-output bundle for the two-digit BCD counter.
// The counter attaches through the slave modport; its driver uses master.
interface bcd_count2_if;
    logic       en;
    logic       up_dn;
    logic       clr;
    logic       load;
    logic [3:0] load_ones;
    logic [3:0] load_tens;
    logic [4:0] bcd_ones;
    logic [4:0] bcd_tens;
    logic       tick;
    logic       carry;

    modport master (
        output en, up_dn, clr, load, load_ones, load_tens,
        input  bcd_ones, bcd_tens, tick, carry
    );

    modport slave (
        input  en, up_dn, clr, load, load_ones, load_tens,
        output bcd_ones, bcd_tens, tick, carry
    );
endinterface

// File: rtl/bcd_count2.sv
// Two-digit BCD up/down counter (00..99) with prescaler, clear, load, tick and carry strobes.
// Define BCD_COUNT2_SATURATE_EN to hold at 99/00 instead of wrapping (carry then flags the limit).
module bcd_count2 #(
    parameter int PRESCALE   = 50000000,
    parameter int PRESCALE_W = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    bcd_count2_if.slave  bus
);

    localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] presc;
    logic [3:0]            ones;
    logic [3:0]            tens;
    logic                  tick_r;
    logic                  carry_r;

    function automatic logic [3:0] clamp9(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            ones    <= '0;
            tens    <= '0;
            tick_r  <= 1'b0;
            carry_r <= 1'b0;
        end else begin
            tick_r  <= 1'b0;
            carry_r <= 1'b0;
            if (bus.clr) begin
                presc <= '0;
                ones  <= '0;
                tens  <= '0;
            end else if (bus.load) begin
                presc <= '0;
                ones  <= clamp9(bus.load_ones);
                tens  <= clamp9(bus.load_tens);
            end else if (bus.en) begin
                if (presc == PRESC_LAST) begin
                    presc  <= '0;
                    tick_r <= 1'b1;
                    if (bus.up_dn) begin
                        if (ones == 4'd9 && tens == 4'd9) begin
                            carry_r <= 1'b1;
`ifdef BCD_COUNT2_SATURATE_EN
                            ones <= ones;
                            tens <= tens;
`else
                            ones <= 4'd0;
                            tens <= 4'd0;
`endif
                        end else if (ones == 4'd9) begin
                            ones <= 4'd0;
                            tens <= tens + 4'd1;
                        end else begin
                            ones <= ones + 4'd1;
                        end
                    end else begin
                        // Borrow path mirrors the carry path: 00 is the lower limit
                        if (ones == 4'd0 && tens == 4'd0) begin
                            carry_r <= 1'b1;
`ifdef BCD_COUNT2_SATURATE_EN
                            ones <= ones;
                            tens <= tens;
`else
                            ones <= 4'd9;
                            tens <= 4'd9;
`endif
                        end else if (ones == 4'd0) begin
                            ones <= 4'd9;
                            tens <= tens - 4'd1;
                        end else begin
                            ones <= ones - 4'd1;
                        end
                    end
                end else begin
                    presc <= presc + PRESCALE_W'(1);
                end
            end
        end
    end

    assign bus.bcd_ones = {1'b0, ones};
    assign bus.bcd_tens = {1'b0, tens};
    assign bus.tick     = tick_r;
    assign bus.carry    = carry_r;

endmodule

// File: tb/tb_bcd_count2.sv
// Randomized and directed bench for bcd_count2 against an integer-valued reference model.
module tb_bcd_count2;
    localparam int P = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_count2_if bus4();
    bcd_count2_if bus1();

    bcd_count2 #(.PRESCALE(P), .PRESCALE_W(3)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    bcd_count2 #(.PRESCALE(1), .PRESCALE_W(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: counter value as a plain integer 0..99 plus an enabled-cycle count
    int m_val = 0;
    int m_cnt = 0;
    int m_tick = 0;
    int m_carry = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int min9(input int v);
        return (v > 9) ? 9 : v;
    endfunction

    function automatic int dval4();
        return int'(bus4.bcd_tens) * 10 + int'(bus4.bcd_ones);
    endfunction

    function automatic int dval1();
        return int'(bus1.bcd_tens) * 10 + int'(bus1.bcd_ones);
    endfunction

    task automatic model_edge();
        m_tick = 0;
        m_carry = 0;
        if (!rst_n || bus4.clr) begin
            m_val = 0;
            m_cnt = 0;
        end else if (bus4.load) begin
            m_val = 10 * min9(int'(bus4.load_tens)) + min9(int'(bus4.load_ones));
            m_cnt = 0;
        end else if (bus4.en) begin
            m_cnt++;
            if (m_cnt == P) begin
                m_cnt = 0;
                m_tick = 1;
                if (bus4.up_dn) begin
                    if (m_val == 99) begin
                        m_carry = 1;
`ifndef BCD_COUNT2_SATURATE_EN
                        m_val = 0;
`endif
                    end else m_val++;
                end else begin
                    if (m_val == 0) begin
                        m_carry = 1;
`ifndef BCD_COUNT2_SATURATE_EN
                        m_val = 99;
`endif
                    end else m_val--;
                end
            end
        end
    endtask

    task automatic check_model();
        chk("ones", {27'd0, bus4.bcd_ones}, m_val % 10);
        chk("tens", {27'd0, bus4.bcd_tens}, m_val / 10);
        chk("tick", {31'd0, bus4.tick}, m_tick);
        chk("carry", {31'd0, bus4.carry}, m_carry);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input logic en, input logic up, input logic c, input logic ld,
                         input logic [3:0] lt, input logic [3:0] lo);
        bus4.en = en;
        bus4.up_dn = up;
        bus4.clr = c;
        bus4.load = ld;
        bus4.load_tens = lt;
        bus4.load_ones = lo;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        bus1.en = 1'b0;
        bus1.up_dn = 1'b1;
        bus1.clr = 1'b0;
        bus1.load = 1'b0;
        bus1.load_tens = 4'd0;
        bus1.load_ones = 4'd0;
        repeat (2) cyc();

        // Release, load 37, run mid-count, then asynchronous reset without a clock edge
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 4'd7);
        cyc();
        chk("load37", dval4(), 37);
        bus4.load = 1'b0;
        repeat (2) cyc();
        #2 rst_n = 1'b0;
        #1;
        m_val = 0; m_cnt = 0; m_tick = 0; m_carry = 0;
        chk("async_rst_val", dval4(), 0);
        chk("async_rst_tick", {31'd0, bus4.tick}, 0);
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("pre_first_tick", {31'd0, bus4.tick}, 0);
        cyc();
        chk("first_tick_val", dval4(), 1);
        chk("first_tick", {31'd0, bus4.tick}, 1);

        // Up wrap from 98
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 4'd8);
        cyc();
        bus4.load = 1'b0;
        repeat (4) cyc();
        chk("up_99", dval4(), 99);
        repeat (4) cyc();
`ifdef BCD_COUNT2_SATURATE_EN
        chk("up_limit_val", dval4(), 99);
`else
        chk("up_wrap_val", dval4(), 0);
`endif
        chk("up_wrap_carry", {31'd0, bus4.carry}, 1);
        cyc();
        chk("carry_one_cycle", {31'd0, bus4.carry}, 0);

        // Down borrow from 10 and from 00
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0);
        cyc();
        bus4.load = 1'b0;
        repeat (4) cyc();
        chk("down_09", dval4(), 9);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        cyc();
        bus4.load = 1'b0;
        repeat (4) cyc();
`ifdef BCD_COUNT2_SATURATE_EN
        chk("down_limit_val", dval4(), 0);
`else
        chk("down_wrap_val", dval4(), 99);
`endif
        chk("down_carry", {31'd0, bus4.carry}, 1);

        // Enable gating: 2 enabled, 10 idle, then 2 more enabled reach the step
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
        cyc();
        bus4.load = 1'b0;
        repeat (2) cyc();
        bus4.en = 1'b0;
        repeat (10) cyc();
        chk("gated_hold", dval4(), 0);
        bus4.en = 1'b1;
        cyc();
        chk("gated_no_tick", {31'd0, bus4.tick}, 0);
        cyc();
        chk("gated_tick", {31'd0, bus4.tick}, 1);

        // Priority and clamp
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 4'd5);
        cyc();
        chk("clr_over_load", dval4(), 0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd12, 4'd15);
        cyc();
        chk("load_clamp", dval4(), 99);
        bus4.load = 1'b0;
        repeat (3) cyc();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 4'd3);
        cyc();
        chk("load_over_step", dval4(), 23);
        chk("load_over_step_tick", {31'd0, bus4.tick}, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);

        // PRESCALE=1 instance: tick every cycle, carry on the 100th
        bus1.en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cyc();
`ifdef BCD_COUNT2_SATURATE_EN
            chk("p1_val", dval1(), (i == 99) ? 99 : i + 1);
`else
            chk("p1_val", dval1(), (i + 1) % 100);
`endif
            chk("p1_tick", {31'd0, bus1.tick}, 1);
            chk("p1_carry", {31'd0, bus1.carry}, (i == 99) ? 1 : 0);
        end
        bus1.en = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus4.en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) bus4.up_dn = $urandom_range(0, 1);
            bus4.clr = ($urandom_range(0, 63) == 0);
            bus4.load = ($urandom_range(0, 39) == 0);
            bus4.load_tens = 4'($urandom_range(0, 15));
            bus4.load_ones = 4'($urandom_range(0, 15));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
